// File: rtl/psum_buffer_ctrl_pkg.sv
// Shared definitions for the psum buffer responder: stall response codes and FSM state encoding.
// The main controller imports the same package so both sides agree on the handshake codes.
package psum_buffer_ctrl_pkg;

    localparam logic [1:0] STALL_BUSY   = 2'b00;
    localparam logic [1:0] STALL_ACCEPT = 2'b10;
    localparam logic [1:0] STALL_ERROR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WRITE      = 2'd1,
        ST_DRAIN      = 2'd2,
        ST_DRAIN_LAST = 2'd3
    } state_t;

endpackage

// File: rtl/psum_buffer_ctrl_mem.sv
// DEPTH x PSUM_WIDTH psum storage: one write port and two registered, enable-gated read ports
// (controller read port and drain port); read registers hold their value while not enabled.
module psum_mem #(
    parameter int unsigned PSUM_WIDTH = 16,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [PSUM_WIDTH-1:0] wdata,
    input  logic                  re_a,
    input  logic [ADDR_WIDTH-1:0] raddr_a,
    output logic [PSUM_WIDTH-1:0] rdata_a,
    input  logic                  re_b,
    input  logic [ADDR_WIDTH-1:0] raddr_b,
    output logic [PSUM_WIDTH-1:0] rdata_b
);

    logic [PSUM_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            if (re_a) begin
                rdata_a <= mem[raddr_a];
            end
            if (re_b) begin
                rdata_b <= mem[raddr_b];
            end
        end
    end

endmodule

// File: rtl/psum_buffer_ctrl.sv
// Responder side of the psum write/read handshake: answers writes with a stall code, serves
// registered reads, owns the read/write pointers and streams valid entries out on drain.
module psum_buffer_ctrl
    import psum_buffer_ctrl_pkg::*;
#(
    parameter int unsigned PSUM_WIDTH = 16,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_req,
    input  logic [PSUM_WIDTH-1:0] wdata,
    input  logic                  psum_mode,
    output logic [1:0]            stall,
    input  logic                  psum_buffer_ren,
    output logic                  can_read_psum,
    output logic                  psum_buffer_valid,
    output logic [PSUM_WIDTH-1:0] psum_rdata,
    input  logic                  next_psum_raddr,
    input  logic                  next_psum_waddr,
    input  logic                  drain_start,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PSUM_WIDTH-1:0] out_data,
    output logic                  drain_done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] raddr, waddr, idx;
    logic [DEPTH-1:0]      valid_bits;
    logic                  pending_wr, mode_q;
    logic [PSUM_WIDTH-1:0] wdata_q;
    logic                  wr_error, mem_we, rd_accept, ptr_enable;
    logic                  drain_load, beat_done, scan_step;

    assign can_read_psum = (state == ST_IDLE) & valid_bits[raddr] & ~write_req;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        wr_error   = 1'b0;
        mem_we     = 1'b0;
        rd_accept  = 1'b0;
        ptr_enable = 1'b0;
        drain_load = 1'b0;
        beat_done  = 1'b0;
        scan_step  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                ptr_enable = 1'b1;
                rd_accept  = psum_buffer_ren & can_read_psum;
                if (pending_wr || write_req) begin
                    state_next = ST_WRITE;
                end else if (drain_start) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_WRITE: begin
                ptr_enable = 1'b1;
                wr_error   = ~mode_q & valid_bits[waddr];
                mem_we     = ~wr_error;
                state_next = ST_IDLE;
            end
            ST_DRAIN: begin
                // Invalid entries advance the index without presenting a beat.
                drain_load = ~out_valid & valid_bits[idx];
                beat_done  = out_valid & out_ready;
                scan_step  = beat_done | (~out_valid & ~valid_bits[idx]);
                if (scan_step && idx == LAST_IDX) begin
                    state_next = ST_DRAIN_LAST;
                end
            end
            ST_DRAIN_LAST: state_next = ST_IDLE;
            default:       state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            raddr             <= '0;
            waddr             <= '0;
            idx               <= '0;
            valid_bits        <= '0;
            pending_wr        <= 1'b0;
            mode_q            <= 1'b0;
            wdata_q           <= '0;
            stall             <= STALL_BUSY;
            psum_buffer_valid <= 1'b0;
            out_valid         <= 1'b0;
            drain_done        <= 1'b0;
        end else begin
            drain_done <= (state == ST_DRAIN) && (state_next == ST_DRAIN_LAST);

            if (state == ST_IDLE) begin
                if (pending_wr) begin
                    pending_wr <= 1'b0;
                end else if (write_req) begin
                    wdata_q <= wdata;
                    mode_q  <= psum_mode;
                    stall   <= STALL_BUSY;
                end else if (drain_start) begin
                    idx <= '0;
                end
            end

            // Writes arriving mid-drain are parked and replayed from IDLE.
            if ((state == ST_DRAIN || state == ST_DRAIN_LAST) && write_req) begin
                pending_wr <= 1'b1;
                wdata_q    <= wdata;
                mode_q     <= psum_mode;
                stall      <= STALL_BUSY;
            end

            if (state == ST_WRITE) begin
                stall <= wr_error ? STALL_ERROR : STALL_ACCEPT;
                if (!wr_error) begin
                    valid_bits[waddr] <= 1'b1;
                end
            end

            if (ptr_enable) begin
                if (next_psum_waddr) begin
                    waddr <= waddr + 1'b1;
                end
                if (next_psum_raddr) begin
                    raddr <= raddr + 1'b1;
                end
            end

            if (rd_accept) begin
                psum_buffer_valid <= 1'b1;
            end else if (ptr_enable && next_psum_raddr) begin
                psum_buffer_valid <= 1'b0;
            end

            if (drain_load) begin
                out_valid <= 1'b1;
            end else if (beat_done) begin
                out_valid <= 1'b0;
            end
            if (beat_done) begin
                valid_bits[idx] <= 1'b0;
            end
            if (scan_step && idx != LAST_IDX) begin
                idx <= idx + 1'b1;
            end

            if (state == ST_DRAIN_LAST) begin
                raddr <= '0;
                waddr <= '0;
            end
        end
    end

    psum_mem #(
        .PSUM_WIDTH(PSUM_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk    (clk),
        .reset  (reset),
        .we     (mem_we),
        .waddr  (waddr),
        .wdata  (wdata_q),
        .re_a   (rd_accept),
        .raddr_a(raddr),
        .rdata_a(psum_rdata),
        .re_b   (drain_load),
        .raddr_b(idx),
        .rdata_b(out_data)
    );

endmodule

// File: tb/tb_psum_buffer_ctrl.sv
// Self-checking bench for psum_buffer_ctrl against an array/queue model of buffer contents,
// pointers and stall responses.
module tb_psum_buffer_ctrl;

    localparam int W = 16;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         write_req, psum_mode, psum_buffer_ren;
    logic [W-1:0] wdata;
    logic [1:0]   stall;
    logic         can_read_psum, psum_buffer_valid;
    logic [W-1:0] psum_rdata, out_data;
    logic         next_psum_raddr, next_psum_waddr, drain_start;
    logic         out_valid, out_ready, drain_done;

    psum_buffer_ctrl #(.PSUM_WIDTH(W), .DEPTH(D)) dut (
        .clk              (clk),
        .reset            (reset),
        .write_req        (write_req),
        .wdata            (wdata),
        .psum_mode        (psum_mode),
        .stall            (stall),
        .psum_buffer_ren  (psum_buffer_ren),
        .can_read_psum    (can_read_psum),
        .psum_buffer_valid(psum_buffer_valid),
        .psum_rdata       (psum_rdata),
        .next_psum_raddr  (next_psum_raddr),
        .next_psum_waddr  (next_psum_waddr),
        .drain_start      (drain_start),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .drain_done       (drain_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: buffer contents, valid flags, pointers, read-port state.
    logic [W-1:0] mm [D];
    bit           mv [D];
    int           mr, mw;
    bit           m_rvalid;
    logic [W-1:0] m_rdata;
    logic [W-1:0] beats [$];
    logic [W-1:0] exp_beats [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) mv[i] = 1'b0;
        mr = 0; mw = 0; m_rvalid = 1'b0; m_rdata = '0;
    endtask

    task automatic model_write(input logic [W-1:0] d, input logic m, output logic [1:0] exp_s);
        if (!m && mv[mw]) begin
            exp_s = 2'b11;
        end else begin
            exp_s = 2'b10;
            mm[mw] = d;
            mv[mw] = 1'b1;
        end
    endtask

    task automatic model_read();
        if (mv[mr]) begin
            m_rvalid = 1'b1;
            m_rdata  = mm[mr];
        end
    endtask

    task automatic model_ptr(input bit r, input bit w);
        if (r) begin mr = (mr + 1) % D; m_rvalid = 1'b0; end
        if (w) mw = (mw + 1) % D;
    endtask

    task automatic model_drain();
        exp_beats.delete();
        for (int i = 0; i < D; i++) if (mv[i]) exp_beats.push_back(mm[i]);
        for (int i = 0; i < D; i++) mv[i] = 1'b0;
        mr = 0; mw = 0;
    endtask

    task automatic write_op(input logic [W-1:0] d, input logic m, output logic [1:0] s1, output logic [1:0] s2);
        write_req = 1'b1; wdata = d; psum_mode = m;
        tick();
        write_req = 1'b0;
        s1 = stall;
        tick();
        s2 = stall;
    endtask

    task automatic read_op(output logic can, output logic v, output logic [W-1:0] dat);
        psum_buffer_ren = 1'b1;
        can = can_read_psum;
        tick();
        psum_buffer_ren = 1'b0;
        v   = psum_buffer_valid;
        dat = psum_rdata;
    endtask

    task automatic ptr_op(input bit r, input bit w);
        next_psum_raddr = r; next_psum_waddr = w;
        tick();
        next_psum_raddr = 1'b0; next_psum_waddr = 1'b0;
    endtask

    // ready_mode: 0 toggles every other cycle, 1 random, 2 always ready.
    task automatic drain_op(input int ready_mode, input int inject, input logic [W-1:0] inj_data,
                            output int done_cnt, output int done_lat, output int hold_bad, output int stall_bad);
        bit           prev_hold, rdy;
        logic [W-1:0] prev_data;
        int           c, extra;
        beats.delete();
        done_cnt = 0; done_lat = -1; hold_bad = 0; stall_bad = 0;
        prev_hold = 1'b0; prev_data = '0; c = 0; extra = 0;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        while (c < 300 && extra < 3) begin
            if (drain_done) begin
                done_cnt++;
                if (done_lat < 0) done_lat = c;
            end
            if (done_cnt > 0) extra++;
            if (prev_hold && (out_valid !== 1'b1 || out_data !== prev_data)) hold_bad++;
            if (inject >= 0 && c > inject && done_cnt == 0 && stall !== 2'b00) stall_bad++;
            case (ready_mode)
                0:       rdy = c[0];
                1:       rdy = ($urandom_range(0, 1) == 1);
                default: rdy = 1'b1;
            endcase
            if (out_valid && rdy) beats.push_back(out_data);
            prev_hold = out_valid && !rdy;
            prev_data = out_data;
            out_ready = rdy;
            write_req = (c == inject);
            if (c == inject) begin
                wdata = inj_data; psum_mode = 1'b0;
            end
            tick();
            c++;
        end
        out_ready = 1'b0;
        write_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        model_reset();
        total++; if (stall !== 2'b00) begin bad++; $display("FAIL reset_stall: got %b expected 00", stall); end
        total++; if (psum_buffer_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", psum_buffer_valid); end
        total++; if (psum_rdata !== '0) begin bad++; $display("FAIL reset_rdata: got %h expected 0", psum_rdata); end
        total++; if (out_valid !== 1'b0 || out_data !== '0) begin bad++; $display("FAIL reset_out: got v=%b d=%h expected v=0 d=0", out_valid, out_data); end
        total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", drain_done); end
        total++; if (can_read_psum !== 1'b0) begin bad++; $display("FAIL reset_can_read: got %b expected 0", can_read_psum); end
    endtask

    task automatic test_write_basic();
        logic [1:0] s1, s2, e;
        write_op(16'h0005, 1'b0, s1, s2);
        model_write(16'h0005, 1'b0, e);
        total++; if (s1 !== 2'b00) begin bad++; $display("FAIL write_stall_t1: got %b expected 00", s1); end
        total++; if (s2 !== e) begin bad++; $display("FAIL write_stall_t2: got %b expected %b", s2, e); end
        total++; if (can_read_psum !== 1'b1) begin bad++; $display("FAIL write_can_read: got %b expected 1", can_read_psum); end
    endtask

    task automatic test_read();
        logic can, v; logic [W-1:0] dat;
        read_op(can, v, dat);
        model_read();
        total++; if (v !== m_rvalid || dat !== m_rdata) begin bad++; $display("FAIL read_data: got v=%b d=%h expected v=%b d=%h", v, dat, m_rvalid, m_rdata); end
        repeat (2) tick();
        total++; if (psum_buffer_valid !== 1'b1 || psum_rdata !== 16'h0005) begin bad++; $display("FAIL read_hold: got v=%b d=%h expected v=1 d=0005", psum_buffer_valid, psum_rdata); end
        ptr_op(1'b1, 1'b0);
        model_ptr(1'b1, 1'b0);
        total++; if (psum_buffer_valid !== m_rvalid) begin bad++; $display("FAIL read_release: got %b expected %b", psum_buffer_valid, m_rvalid); end
        total++; if (can_read_psum !== mv[mr]) begin bad++; $display("FAIL read_raddr1: got %b expected %b", can_read_psum, mv[mr]); end
    endtask

    task automatic test_overwrite();
        logic [1:0] s1, s2, e;
        logic can, v; logic [W-1:0] dat, d;
        d = W'($urandom);
        write_op(d, 1'b0, s1, s2);
        model_write(d, 1'b0, e);
        total++; if (s2 !== e) begin bad++; $display("FAIL overwrite_err: got %b expected %b", s2, e); end
        repeat (D - 1) begin ptr_op(1'b1, 1'b0); model_ptr(1'b1, 1'b0); end
        read_op(can, v, dat);
        model_read();
        total++; if (v !== m_rvalid || dat !== m_rdata) begin bad++; $display("FAIL overwrite_keep: got v=%b d=%h expected v=%b d=%h", v, dat, m_rvalid, m_rdata); end
        write_op(16'h0009, 1'b1, s1, s2);
        model_write(16'h0009, 1'b1, e);
        total++; if (s2 !== e) begin bad++; $display("FAIL overwrite_acc: got %b expected %b", s2, e); end
        read_op(can, v, dat);
        model_read();
        total++; if (dat !== m_rdata) begin bad++; $display("FAIL overwrite_data: got %h expected %h", dat, m_rdata); end
    endtask

    task automatic test_drain_sparse();
        logic [1:0] s1, s2, e;
        int dc, dl, hb, sb;
        for (int i = 1; i < D; i++) begin
            ptr_op(1'b0, 1'b1); model_ptr(1'b0, 1'b1);
            if (i == 2 || i == 5) begin
                logic [W-1:0] d;
                d = W'($urandom);
                write_op(d, 1'b0, s1, s2);
                model_write(d, 1'b0, e);
                total++; if (s2 !== e) begin bad++; $display("FAIL fill_stall: got %b expected %b", s2, e); end
            end
        end
        model_drain();
        drain_op(0, -1, '0, dc, dl, hb, sb);
        total++; if (beats.size() != exp_beats.size()) begin bad++; $display("FAIL drain_beats: got %0d expected %0d", beats.size(), exp_beats.size()); end
        for (int i = 0; i < beats.size() && i < exp_beats.size(); i++) begin
            total++; if (beats[i] !== exp_beats[i]) begin bad++; $display("FAIL drain_data%0d: got %h expected %h", i, beats[i], exp_beats[i]); end
        end
        total++; if (hb != 0) begin bad++; $display("FAIL drain_hold: got %0d expected 0", hb); end
        total++; if (dc != 1) begin bad++; $display("FAIL drain_done_cnt: got %0d expected 1", dc); end
        total++; if (can_read_psum !== mv[mr]) begin bad++; $display("FAIL drain_cleared: got %b expected %b", can_read_psum, mv[mr]); end
    endtask

    task automatic test_drain_empty();
        int dc, dl, hb, sb;
        model_drain();
        drain_op(2, -1, '0, dc, dl, hb, sb);
        total++; if (beats.size() != 0) begin bad++; $display("FAIL empty_beats: got %0d expected 0", beats.size()); end
        total++; if (dc != 1 || dl != D) begin bad++; $display("FAIL empty_done: got cnt=%0d lat=%0d expected cnt=1 lat=%0d", dc, dl, D); end
    endtask

    task automatic test_write_during_drain();
        logic [1:0] s1, s2, e;
        logic [W-1:0] d;
        logic can, v; logic [W-1:0] dat;
        int dc, dl, hb, sb, waited;
        for (int i = 0; i < D; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                d = W'($urandom);
                write_op(d, 1'b0, s1, s2);
                model_write(d, 1'b0, e);
                total++; if (s2 !== e) begin bad++; $display("FAIL wdd_fill: got %b expected %b", s2, e); end
            end
            ptr_op(1'b0, 1'b1); model_ptr(1'b0, 1'b1);
        end
        model_drain();
        d = W'($urandom);
        drain_op(1, 2, d, dc, dl, hb, sb);
        total++; if (beats.size() != exp_beats.size()) begin bad++; $display("FAIL wdd_beats: got %0d expected %0d", beats.size(), exp_beats.size()); end
        for (int i = 0; i < beats.size() && i < exp_beats.size(); i++) begin
            total++; if (beats[i] !== exp_beats[i]) begin bad++; $display("FAIL wdd_data%0d: got %h expected %h", i, beats[i], exp_beats[i]); end
        end
        total++; if (sb != 0 || dc != 1) begin bad++; $display("FAIL wdd_stall_busy: got nonbusy=%0d done=%0d expected 0 and 1", sb, dc); end
        model_write(d, 1'b0, e);
        waited = 0;
        while (stall === 2'b00 && waited < 6) begin tick(); waited++; end
        total++; if (stall !== e) begin bad++; $display("FAIL wdd_pending: got %b expected %b", stall, e); end
        read_op(can, v, dat);
        model_read();
        total++; if (v !== m_rvalid || dat !== m_rdata) begin bad++; $display("FAIL wdd_read: got v=%b d=%h expected v=%b d=%h", v, dat, m_rvalid, m_rdata); end
    endtask

    task automatic test_random_rw();
        logic [1:0] s1, s2, e;
        logic can, v; logic [W-1:0] dat, d;
        bit r, w, m;
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    d = W'($urandom);
                    m = ($urandom_range(0, 3) == 0);
                    write_op(d, m, s1, s2);
                    model_write(d, m, e);
                    total++; if (s1 !== 2'b00 || s2 !== e) begin bad++; $display("FAIL rnd_write: got %b/%b expected 00/%b", s1, s2, e); end
                end
                1: begin
                    read_op(can, v, dat);
                    total++; if (can !== mv[mr]) begin bad++; $display("FAIL rnd_can_read: got %b expected %b", can, mv[mr]); end
                    model_read();
                    total++; if (v !== m_rvalid || dat !== m_rdata) begin bad++; $display("FAIL rnd_read: got v=%b d=%h expected v=%b d=%h", v, dat, m_rvalid, m_rdata); end
                end
                2: begin
                    r = $urandom_range(0, 1) == 1;
                    w = $urandom_range(0, 1) == 1;
                    ptr_op(r, w);
                    model_ptr(r, w);
                    total++; if (psum_buffer_valid !== m_rvalid) begin bad++; $display("FAIL rnd_ptr_valid: got %b expected %b", psum_buffer_valid, m_rvalid); end
                end
                default: begin
                    tick();
                    total++; if (can_read_psum !== mv[mr]) begin bad++; $display("FAIL rnd_idle: got %b expected %b", can_read_psum, mv[mr]); end
                end
            endcase
        end
    endtask

    task automatic test_reset_in_write();
        int dc, dl, hb, sb;
        write_req = 1'b1; wdata = W'($urandom); psum_mode = 1'b1;
        tick();
        write_req = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_reset();
        total++; if (stall !== 2'b00) begin bad++; $display("FAIL rst_write_stall: got %b expected 00", stall); end
        total++; if (can_read_psum !== 1'b0 || psum_buffer_valid !== 1'b0) begin bad++; $display("FAIL rst_write_state: got can=%b v=%b expected 0 0", can_read_psum, psum_buffer_valid); end
        model_drain();
        drain_op(2, -1, '0, dc, dl, hb, sb);
        total++; if (beats.size() != 0 || dc != 1) begin bad++; $display("FAIL rst_write_empty: got beats=%0d done=%0d expected 0 1", beats.size(), dc); end
    endtask

    initial begin
        reset = 1'b0; write_req = 1'b0; wdata = '0; psum_mode = 1'b0;
        psum_buffer_ren = 1'b0; next_psum_raddr = 1'b0; next_psum_waddr = 1'b0;
        drain_start = 1'b0; out_ready = 1'b0;
        #1;
        test_reset();
        test_write_basic();
        test_read();
        test_overwrite();
        test_drain_sparse();
        test_drain_empty();
        test_write_during_drain();
        test_random_rw();
        test_reset_in_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000");
        $fatal(1);
    end

endmodule
